spi_master40: RTL and testbench
===============================

Name: spi_master40

Overview:
- SPI master that drives the same 40-bit frame the DE0-Nano SPI slave port accepts: 8-bit address followed by 32-bit data, MSB first.
- Used as the bench/companion-board initiator that reads odometer, encoder and sonar registers from the slave.
- Also used as an on-board master for add-on peripherals.
- Full-duplex: shifts {tx_addr, tx_data} out on mosi while capturing {rx_addr, rx_data} from miso.

Parameters:
- CLK_DIV, 25, clk cycles per sck half-period (sck = clk / (2*CLK_DIV)); legal range 2..255.
- CS_SETUP, 4, clk cycles from cs_n falling to the first sck rising edge is CS_SETUP + CLK_DIV.
- CS_HOLD, 4, clk cycles from the last sck falling edge to cs_n rising.
- CS_GAP, 8, minimum clk cycles cs_n stays high between frames (busy held).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a frame; sampled only in IDLE.
- tx_addr  in  8  address byte, latched on accepted start.
- tx_data  in  32  data word, latched on accepted start.
- busy  out  1  high from the cycle after start acceptance through the end of GAP.
- done  out  1  one-cycle pulse; rx_* are valid from this cycle.
- rx_addr  out  8  frame bits 39:32 received on miso.
- rx_data  out  32  frame bits 31:0 received on miso.
- sck  out  1  SPI clock, idle low (mode 0).
- cs_n  out  1  chip select, active low, idle high.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

Behaviour:
- Reset values: busy=0, done=0, rx_addr=0, rx_data=0, sck=0, cs_n=1, mosi=0; FSM enters IDLE.
- Reset mid-frame: on the next edge cs_n=1 and sck=0; no done pulse; rx_* cleared.
- Mode 0: mosi changes only while sck is low; miso is sampled into the shift register in the same clk cycle in which sck is driven 0->1.
- FSM states:
  - IDLE: on start=1, latch shift_tx={tx_addr,tx_data}. Next cycle: cs_n=0, busy=1, mosi=bit39 -> SETUP.
  - SETUP: wait CS_SETUP cycles, sck low -> SHIFT.
  - SHIFT: 40 bits. Each bit is CLK_DIV cycles with sck low, then CLK_DIV cycles with sck high.
    - On the rising transition, shift miso into the LSB of shift_rx.
    - On the falling transition, present the next tx bit on mosi.
    - After the 40th high phase, sck=0 -> HOLD.
    - Bit counter 6 bits; count 0..39; no wrap.
  - HOLD: CS_HOLD cycles, sck=0, mosi holds bit0. Then cs_n=1, done=1 and rx_addr/rx_data={shift_rx} in the same cycle -> GAP.
  - GAP: CS_GAP cycles, cs_n=1, busy=1. Then busy=0 -> IDLE.
- Frame length: cs_n low for exactly CS_SETUP + 80*CLK_DIV + CS_HOLD cycles.
- Exactly 40 sck rising edges per frame; no sck edges while cs_n=1.
- start while busy=1 is ignored (not queued). tx_* changes after acceptance do not affect the frame in flight.
- start held high continuously: the next frame is accepted in the first IDLE cycle after GAP, giving back-to-back frames separated by CS_GAP+1 high cycles of cs_n.
- rx_* hold their value until the next done or reset.
- done never coincides with busy=0.

Test Plan:
- Loopback (miso tied to mosi), CLK_DIV=2, tx_addr=8'h05, tx_data=32'hDEADBEEF, start pulse -> done once; rx_addr=8'h05, rx_data=32'hDEADBEEF; cs_n low for 4+160+4=168 cycles.
- Slave model (mode 0, shifts out on sck falling edge, first bit driven at cs_n fall) returning 40'hA5_12345678, tx_addr=8'h00 -> rx_addr=8'hA5, rx_data=32'h12345678. Checker confirms mosi stable across every sck rising edge and exactly 40 rising edges.
- Default CLK_DIV=25 -> measured sck period 50 clk cycles (1 MHz); first sck rise at 4+25 cycles after cs_n fall.
- Start pulsed during SHIFT with tx_addr=8'hFF -> ignored; the single frame completes with the original data; exactly one done.
- reset asserted at bit 20 -> next cycle cs_n=1, sck=0, busy=0, rx_data=0; no done. New start after reset yields a correct full frame.
- start held high for 3 frames with incrementing tx_addr 0,1,2 -> 3 done pulses; cs_n high for 9 cycles between frames; slave model sees addresses 0,1,2 in order.

Source files
------------

// File: rtl/spi_master40.sv
// SPI mode-0 master for the 40-bit {addr[7:0], data[31:0]} frame, MSB first.
// Full duplex: the tx word goes out on mosi while the rx word is captured from miso.
module spi_master40 #(
  parameter int CLK_DIV  = 25,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  tx_addr,
  input  logic [31:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rx_addr,
  output logic [31:0] rx_data,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  // state | meaning
  // IDLE  | cs_n high, waiting for start
  // SETUP | cs_n low, sck low, CS_SETUP cycles before the first low phase
  // SHIFT | 40 bits, CLK_DIV cycles sck low then CLK_DIV cycles sck high
  // HOLD  | sck low, last bit held on mosi for CS_HOLD cycles
  // GAP   | cs_n high, busy held for CS_GAP cycles
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);

  state_t      state, state_nxt;
  logic [7:0]  tmr, tmr_nxt;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [39:0] shift_tx, shift_tx_nxt;
  logic [39:0] shift_rx, shift_rx_nxt;
  logic        busy_nxt, done_nxt, sck_nxt, cs_n_nxt, mosi_nxt;
  logic [7:0]  rx_addr_nxt;
  logic [31:0] rx_data_nxt;

  // All outputs are registered so sck/cs_n/mosi are glitch-free at the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tmr      <= '0;
      bit_cnt  <= '0;
      shift_tx <= '0;
      shift_rx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_addr  <= '0;
      rx_data  <= '0;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift_tx <= shift_tx_nxt;
      shift_rx <= shift_rx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      rx_addr  <= rx_addr_nxt;
      rx_data  <= rx_data_nxt;
      sck      <= sck_nxt;
      cs_n     <= cs_n_nxt;
      mosi     <= mosi_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tmr_nxt      = tmr;
    bit_cnt_nxt  = bit_cnt;
    shift_tx_nxt = shift_tx;
    shift_rx_nxt = shift_rx;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    rx_addr_nxt  = rx_addr;
    rx_data_nxt  = rx_data;
    sck_nxt      = sck;
    cs_n_nxt     = cs_n;
    mosi_nxt     = mosi;

    case (state)
      IDLE: begin
        if (start) begin
          shift_tx_nxt = {tx_addr, tx_data};
          mosi_nxt     = tx_addr[7];
          cs_n_nxt     = 1'b0;
          busy_nxt     = 1'b1;
          tmr_nxt      = SETUP_LD;
          state_nxt    = SETUP;
        end
      end
      SETUP: begin
        if (tmr == 8'd0) begin
          tmr_nxt     = DIV_LD;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
      SHIFT: begin
        if (tmr != 8'd0) begin
          tmr_nxt = tmr - 8'd1;
        end else if (!sck) begin
          sck_nxt      = 1'b1;
          shift_rx_nxt = {shift_rx[38:0], miso};
          tmr_nxt      = DIV_LD;
        end else begin
          sck_nxt = 1'b0;
          if (bit_cnt == 6'd39) begin
            tmr_nxt   = HOLD_LD;
            state_nxt = HOLD;
          end else begin
            bit_cnt_nxt  = bit_cnt + 6'd1;
            shift_tx_nxt = {shift_tx[38:0], 1'b0};
            mosi_nxt     = shift_tx[38];
            tmr_nxt      = DIV_LD;
          end
        end
      end
      HOLD: begin
        if (tmr == 8'd0) begin
          cs_n_nxt    = 1'b1;
          done_nxt    = 1'b1;
          rx_addr_nxt = shift_rx[39:32];
          rx_data_nxt = shift_rx[31:0];
          tmr_nxt     = GAP_LD;
          state_nxt   = GAP;
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
      GAP: begin
        if (tmr == 8'd0) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master40.sv
// Bench for spi_master40: table-driven frames against a mode-0 slave model,
// plus hand-written sequences for abort, ignored start, back-to-back and timing.
`timescale 1ns/1ps
module tb_spi_master40;

  logic        clk = 1'b0;
  logic        reset, start, miso, loopback;
  logic [7:0]  tx_addr, rx_addr;
  logic [31:0] tx_data, rx_data;
  logic        busy, done, sck, cs_n, mosi;

  logic        start25;
  logic [7:0]  tx_addr25, rx_addr25;
  logic [31:0] tx_data25, rx_data25;
  logic        busy25, done25, sck25, cs_n25, mosi25;

  always #5 clk = ~clk;

  spi_master40 #(.CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_addr(tx_addr), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_addr(rx_addr), .rx_data(rx_data),
    .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master40 dut25 (
    .clk(clk), .reset(reset), .start(start25), .tx_addr(tx_addr25), .tx_data(tx_data25),
    .busy(busy25), .done(done25), .rx_addr(rx_addr25), .rx_data(rx_data25),
    .sck(sck25), .cs_n(cs_n25), .mosi(mosi25), .miso(mosi25)
  );

  // Mode-0 slave: first bit at cs_n fall, next bit on each sck fall, mosi captured on sck rise.
  logic [39:0] slv_resp, slv_sh, slv_cap;
  logic        slv_miso;
  logic [7:0]  slv_addrs[$];

  initial begin
    slv_sh = '0; slv_cap = '0; slv_miso = 1'b0;
  end
  always @(negedge cs_n) begin
    slv_sh   = slv_resp;
    slv_miso = slv_sh[39];
    slv_cap  = '0;
  end
  always @(negedge sck) if (!cs_n) begin
    slv_sh   = {slv_sh[38:0], 1'b0};
    slv_miso = slv_sh[39];
  end
  always @(posedge sck) if (!cs_n) slv_cap = {slv_cap[38:0], mosi};
  always @(posedge cs_n) if (!reset) slv_addrs.push_back(slv_cap[39:32]);

  assign miso = loopback ? mosi : slv_miso;

  // Pin-level monitor sampled on the falling clk edge.
  logic prev_sck = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1, prev_rst = 1'b1;
  int   proto_err = 0, low_cnt = 0, last_low = 0, hi_cnt = 0, last_gap = 0;
  int   rises = 0, last_rises = 0, done_cnt = 0;

  always @(negedge clk) begin
    prev_sck  <= sck;
    prev_mosi <= mosi;
    prev_cs   <= cs_n;
    prev_rst  <= reset;
    if (!reset && !prev_rst) begin
      if ((mosi != prev_mosi && sck) || (sck != prev_sck && (cs_n || prev_cs)))
        proto_err <= proto_err + 1;
      if (!cs_n && prev_cs) begin
        low_cnt  <= 1;
        last_gap <= hi_cnt;
        rises    <= 0;
      end else begin
        if (!cs_n) low_cnt <= low_cnt + 1;
        if (sck && !prev_sck) rises <= rises + 1;
      end
      if (cs_n && !prev_cs) begin
        last_low <= low_cnt;
        hi_cnt   <= 1;
      end else if (cs_n) begin
        hi_cnt <= hi_cnt + 1;
      end
      if (done) begin
        done_cnt   <= done_cnt + 1;
        last_rises <= rises;
        if (!busy) proto_err <= proto_err + 1;
      end
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done) begin ok = 1'b1; break; end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy) begin ok = 1'b1; break; end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [39:0] resp;
    logic        loop;
    logic [39:0] exp_rx;
    logic [39:0] exp_cap;
  } vec_t;

  // Reference: the master returns whatever arrived on miso, and the slave sees the tx frame.
  function automatic vec_t mk_vec(logic [7:0] a, logic [31:0] d, logic [39:0] r, logic lp);
    vec_t v;
    v.addr = a; v.data = d; v.resp = r; v.loop = lp;
    v.exp_rx  = lp ? {a, d} : r;
    v.exp_cap = {a, d};
    return v;
  endfunction

  task automatic run_frame(input vec_t v, input bit inject);
    int  dc0;
    bit  ok;
    tx_addr  = v.addr;
    tx_data  = v.data;
    slv_resp = v.resp;
    loopback = v.loop;
    dc0      = done_cnt;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    if (inject) begin
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        tick();
        if (rises >= 10) begin ok = 1'b1; break; end
      end
      chk("inject_reach_bit10", 64'(ok), 64'd1);
      tx_addr = 8'hFF;
      tx_data = ~v.data;
      start   = 1'b1;
      tick();
      start   = 1'b0;
    end
    wait_done("frame_done");
    chk("rx_addr", 64'(rx_addr), 64'(v.exp_rx[39:32]));
    chk("rx_data", 64'(rx_data), 64'(v.exp_rx[31:0]));
    chk("slave_capture", 64'(slv_cap), 64'(v.exp_cap));
    chk("cs_low_cycles", 64'(last_low), 64'd168);
    chk("sck_rises", 64'(last_rises), 64'd40);
    wait_idle("frame_idle");
    chk("one_done", 64'(done_cnt - dc0), 64'd1);
    chk("protocol", 64'(proto_err), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, m, dc0;
    bit ok;
    logic [31:0] d;
    logic [39:0] r;

    reset = 1'b1; start = 1'b0; tx_addr = '0; tx_data = '0;
    start25 = 1'b0; tx_addr25 = '0; tx_data25 = '0;
    loopback = 1'b1; slv_resp = '0;

    vecs[0] = mk_vec(8'h05, 32'hDEADBEEF, 40'h0, 1'b1);
    vecs[1] = mk_vec(8'h00, 32'h0BADF00D, 40'hA5_12345678, 1'b0);
    for (int i = 2; i < 8; i++)
      vecs[i] = mk_vec(8'($urandom), $urandom, {8'($urandom), 32'($urandom)},
                       1'($urandom_range(0, 1)));

    repeat (4) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rx_addr", 64'(rx_addr), 64'd0);
    chk("rst_rx_data", 64'(rx_data), 64'd0);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_cs_n", 64'(cs_n), 64'd1);
    chk("rst_mosi", 64'(mosi), 64'd0);
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 8; i++) run_frame(vecs[i], 1'b0);

    // Start during SHIFT with different tx_* must be ignored.
    dc0 = done_cnt;
    run_frame(mk_vec(8'h3C, 32'hC001D00D, 40'h5A_A5A5F00F, 1'b0), 1'b1);
    repeat (20) tick();
    chk("ignored_start_done_cnt", 64'(done_cnt - dc0), 64'd1);
    chk("ignored_start_idle", 64'(busy), 64'd0);

    // Reset around bit 20 aborts the frame.
    tx_addr = 8'h77; tx_data = 32'h13579BDF; slv_resp = 40'hFF_FFFFFFFF; loopback = 1'b0;
    dc0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (rises >= 20) begin ok = 1'b1; break; end
    end
    chk("abort_reach_bit20", 64'(ok), 64'd1);
    reset = 1'b1;
    tick();
    chk("abort_cs_n", 64'(cs_n), 64'd1);
    chk("abort_sck", 64'(sck), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rx_data", 64'(rx_data), 64'd0);
    chk("abort_rx_addr", 64'(rx_addr), 64'd0);
    reset = 1'b0;
    repeat (30) tick();
    chk("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    run_frame(mk_vec(8'hC3, $urandom, {8'($urandom), 32'($urandom)}, 1'b0), 1'b0);

    // start held high: three back-to-back frames with addresses 0,1,2.
    slv_addrs.delete();
    dc0 = done_cnt;
    d = $urandom; r = {8'($urandom), 32'($urandom)};
    tx_addr = 8'd0; tx_data = d; slv_resp = r; loopback = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done("b2b_done");
      chk("b2b_rx", 64'({rx_addr, rx_data}), 64'(r));
      if (k > 0) chk("b2b_gap", 64'(last_gap), 64'd9);
      tx_addr = 8'(k + 1);
      if (k == 2) start = 1'b0;
    end
    wait_idle("b2b_idle");
    repeat (20) tick();
    chk("b2b_done_cnt", 64'(done_cnt - dc0), 64'd3);
    chk("b2b_addr_count", 64'(slv_addrs.size()), 64'd3);
    for (int k = 0; k < 3 && k < slv_addrs.size(); k++)
      chk("b2b_addr_order", 64'(slv_addrs[k]), 64'(k));

    // Default divider: first rise 29 cycles after cs_n fall, 50-cycle sck period.
    tx_addr25 = 8'h5A; tx_data25 = 32'h0F1E2D3C;
    start25 = 1'b1; tick(); start25 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!cs_n25) begin ok = 1'b1; break; end
      tick();
    end
    chk("div25_cs_fall", 64'(ok), 64'd1);
    n = 0;
    while (!sck25 && n < 200) begin tick(); n++; end
    chk("div25_first_rise", 64'(n), 64'd29);
    m = 0;
    while (sck25 && m < 200) begin tick(); m++; end
    while (!sck25 && m < 200) begin tick(); m++; end
    chk("div25_period", 64'(m), 64'd50);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done25) begin ok = 1'b1; break; end
    end
    chk("div25_done", 64'(ok), 64'd1);
    chk("div25_rx", 64'({rx_addr25, rx_data25}), 64'({8'h5A, 32'h0F1E2D3C}));

    chk("protocol_final", 64'(proto_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
